pipe_reg_skid: RTL and testbench

//   Parametrised pipeline register: DEPTH chained stages of WIDTH-bit registers with valid/ready flow control.

---
 rtl/pipe_reg_skid_pkg.sv | 17 +
 rtl/pipe_stage.sv | 106 ++++++++++
 rtl/pipe_reg_skid.sv | 71 +++++++
 tb/tb_pipe_reg_skid.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_reg_skid_pkg.sv
// Shared types and sizing helpers for the pipe_reg_skid pipeline register.
package pipe_reg_skid_pkg;

  localparam int unsigned STAGE_CNT_W = 2;

  typedef logic [STAGE_CNT_W-1:0] stageCount_t;

  function automatic int unsigned stageCapacity(input bit skid);
    return skid ? 2 : 1;
  endfunction

  // Width needed to hold every word the whole chain can store, including zero.
  function automatic int unsigned countWidth(input int unsigned depth, input bit skid);
    return $clog2(depth * stageCapacity(skid) + 1);
  endfunction

endpackage

// File: rtl/pipe_stage.sv
// One valid/ready pipeline stage: main register plus an optional skid register.
module pipe_stage
  import pipe_reg_skid_pkg::*;
#(
  parameter int unsigned      WIDTH     = 8,
  parameter bit               SKID      = 1'b1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             flush_i,
  input  logic             inValid_i,
  output logic             inReady_o,
  input  logic [WIDTH-1:0] inData_i,
  output logic             outValid_o,
  input  logic             outReady_i,
  output logic [WIDTH-1:0] outData_o,
  output stageCount_t      count_o
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_MAIN  = 2'b10,
    ST_BOTH  = 2'b11
  } stageState_e;

  stageState_e      state_q, state_d;
  logic [WIDTH-1:0] mainData_q, mainData_d;
  logic [WIDTH-1:0] skidData_q, skidData_d;
  logic             mainValid, skidValid;
  logic             inFire, outFire;

  assign mainValid = (state_q != ST_EMPTY);
  assign skidValid = (state_q == ST_BOTH);

  // With a skid register the ready is purely registered; without it, ready looks through to downstream.
  assign inReady_o  = SKID ? !skidValid : (!mainValid || outReady_i);
  assign outValid_o = mainValid;
  assign outData_o  = mainData_q;
  assign count_o    = {1'b0, mainValid} + {1'b0, skidValid};

  assign inFire  = inValid_i && inReady_o;
  assign outFire = mainValid && outReady_i;

  always_comb begin
    state_d    = state_q;
    mainData_d = mainData_q;
    skidData_d = skidData_q;
    case (state_q)
      ST_EMPTY: begin
        if (inFire) begin
          mainData_d = inData_i;
          state_d    = ST_MAIN;
        end
      end
      ST_MAIN: begin
        if (outFire) begin
          if (inFire) begin
            mainData_d = inData_i;
          end else begin
            state_d = ST_EMPTY;
          end
        end else if (inFire && SKID) begin
          skidData_d = inData_i;
          state_d    = ST_BOTH;
        end
      end
      ST_BOTH: begin
        if (outFire) begin
          mainData_d = skidData_q;
          if (inFire) begin
            skidData_d = inData_i;
          end else begin
            state_d = ST_MAIN;
          end
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    // A flush empties the stage but leaves the data registers untouched; the offered word is dropped.
    if (flush_i) begin
      state_d    = ST_EMPTY;
      mainData_d = mainData_q;
      skidData_d = skidData_q;
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      mainData_q <= RESET_VAL;
      skidData_q <= RESET_VAL;
    end else begin
      mainData_q <= mainData_d;
      skidData_q <= skidData_d;
    end
  end

endmodule

// File: rtl/pipe_reg_skid.sv
// Parametrised pipeline register: DEPTH chained valid/ready stages with optional skid buffering.
module pipe_reg_skid
  import pipe_reg_skid_pkg::*;
#(
  parameter int unsigned      WIDTH     = 8,
  parameter int unsigned      DEPTH     = 2,
  parameter bit               SKID      = 1'b1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                                 C,
  input  logic                                 R,
  input  logic                                 FLUSH,
  input  logic                                 IN_VALID,
  output logic                                 IN_READY,
  input  logic [WIDTH-1:0]                     D,
  output logic                                 OUT_VALID,
  input  logic                                 OUT_READY,
  output logic [WIDTH-1:0]                     Q,
  output logic [countWidth(DEPTH, SKID)-1:0]   COUNT
);

  localparam int unsigned CNT_W = countWidth(DEPTH, SKID);

  logic [DEPTH:0]   chainValid;
  logic [WIDTH-1:0] chainData [DEPTH+1];
  stageCount_t      stageCount [DEPTH];

  assign chainValid[0] = IN_VALID;
  assign chainData[0]  = D;

  // Ready wires live inside each generate block so the SKID=0 ready chain is not one self-referencing vector.
  for (genvar i = 0; i < DEPTH; i++) begin : gStage
    logic upReady;
    logic downReady;

    if (i == DEPTH - 1) begin : gLast
      assign downReady = OUT_READY;
    end else begin : gMid
      assign downReady = gStage[i+1].upReady;
    end

    pipe_stage #(
      .WIDTH    (WIDTH),
      .SKID     (SKID),
      .RESET_VAL(RESET_VAL)
    ) uStage (
      .clock_i   (C),
      .reset_i   (R),
      .flush_i   (FLUSH),
      .inValid_i (chainValid[i]),
      .inReady_o (upReady),
      .inData_i  (chainData[i]),
      .outValid_o(chainValid[i+1]),
      .outReady_i(downReady),
      .outData_o (chainData[i+1]),
      .count_o   (stageCount[i])
    );
  end

  assign IN_READY  = gStage[0].upReady;
  assign OUT_VALID = chainValid[DEPTH];
  assign Q         = chainData[DEPTH];

  always_comb begin
    COUNT = '0;
    for (int i = 0; i < DEPTH; i++) begin
      COUNT = COUNT + CNT_W'(stageCount[i]);
    end
  end

endmodule

// File: tb/tb_pipe_reg_skid.sv
// Directed bench for pipe_reg_skid: a DEPTH=2 skid instance and a DEPTH=1 pass-through instance.
module tb_pipe_reg_skid;

  logic       clock;
  logic       R;
  logic       FLUSH;

  logic       aInValid, aInReady, aOutValid, aOutReady;
  logic [7:0] aD, aQ;
  logic [2:0] aCount;

  logic       bInValid, bInReady, bOutValid, bOutReady;
  logic [7:0] bD, bQ;
  logic [0:0] bCount;

  int assertCount = 0;
  int failCount   = 0;

  // Hand-derived backpressure trace for DEPTH=2, SKID=1 while OUT_READY=0.
  int bpCount [7] = '{0, 1, 2, 3, 4, 4, 4};
  int bpReady [7] = '{1, 1, 1, 1, 0, 0, 0};
  int bpValid [7] = '{0, 0, 1, 1, 1, 1, 1};
  int drQ     [5] = '{8'h20, 8'h21, 8'h22, 8'h23, 8'h23};
  int drValid [5] = '{1, 1, 1, 1, 0};
  int drCount [5] = '{4, 3, 2, 1, 0};

  pipe_reg_skid #(
    .WIDTH(8), .DEPTH(2), .SKID(1'b1), .RESET_VAL(8'h3C)
  ) dutA (
    .C(clock), .R(R), .FLUSH(FLUSH),
    .IN_VALID(aInValid), .IN_READY(aInReady), .D(aD),
    .OUT_VALID(aOutValid), .OUT_READY(aOutReady), .Q(aQ), .COUNT(aCount)
  );

  pipe_reg_skid #(
    .WIDTH(8), .DEPTH(1), .SKID(1'b0), .RESET_VAL(8'h00)
  ) dutB (
    .C(clock), .R(R), .FLUSH(FLUSH),
    .IN_VALID(bInValid), .IN_READY(bInReady), .D(bD),
    .OUT_VALID(bOutValid), .OUT_READY(bOutReady), .Q(bQ), .COUNT(bCount)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [7:0] data, input logic outReady);
    aInValid  = valid;
    aD        = data;
    aOutReady = outReady;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    R = 1'b1;
    FLUSH = 1'b0;
    applyStimulus(1'b1, 8'hA5, 1'b1);
    bInValid = 1'b0; bD = 8'h00; bOutReady = 1'b0;

    $display("[TB] reset");
    for (int k = 0; k < 2; k++) begin
      tick();
      checkOutput("rst_valid", aOutValid, 0);
      checkOutput("rst_q", aQ, 8'h3C);
      checkOutput("rst_count", aCount, 0);
    end
    R = 1'b0;
    applyStimulus(1'b0, 8'h00, 1'b1);
    #1;
    checkOutput("rst_ready", aInReady, 1);
    checkOutput("rst_valid_after", aOutValid, 0);
    checkOutput("rst_q_after", aQ, 8'h3C);
    checkOutput("rstB_valid", bOutValid, 0);
    checkOutput("rstB_q", bQ, 8'h00);
    checkOutput("rstB_count", bCount, 0);

    $display("[TB] streaming");
    for (int j = 0; j < 20; j++) begin
      applyStimulus(j < 16, 8'(j + 1), 1'b1);
      #1;
      if (j < 16) checkOutput("stream_ready", aInReady, 1);
      if (j >= 2 && j < 18) begin
        checkOutput("stream_valid", aOutValid, 1);
        checkOutput("stream_q", aQ, 32'(j - 1));
      end else begin
        checkOutput("stream_idle", aOutValid, 0);
      end
      if (j == 18) checkOutput("stream_hold_last", aQ, 8'h10);
      tick();
    end

    $display("[TB] backpressure");
    for (int k = 0; k < 7; k++) begin
      applyStimulus(1'b1, 8'(32'h20 + ((k < 4) ? k : 4)), 1'b0);
      #1;
      checkOutput("bp_count", aCount, 32'(bpCount[k]));
      checkOutput("bp_ready", aInReady, 32'(bpReady[k]));
      checkOutput("bp_valid", aOutValid, 32'(bpValid[k]));
      if (bpValid[k] == 1) checkOutput("bp_q_hold", aQ, 8'h20);
      tick();
    end
    for (int r = 0; r < 5; r++) begin
      applyStimulus(1'b0, 8'h00, 1'b1);
      #1;
      checkOutput("drain_valid", aOutValid, 32'(drValid[r]));
      checkOutput("drain_count", aCount, 32'(drCount[r]));
      checkOutput("drain_q", aQ, 32'(drQ[r]));
      tick();
    end

    $display("[TB] flush");
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 8'(32'h30 + k), 1'b0);
      tick();
    end
    checkOutput("flush_pre_count", aCount, 3);
    checkOutput("flush_pre_q", aQ, 8'h30);
    FLUSH = 1'b1;
    applyStimulus(1'b1, 8'h55, 1'b0);
    tick();
    FLUSH = 1'b0;
    applyStimulus(1'b0, 8'h00, 1'b1);
    #1;
    checkOutput("flush_count", aCount, 0);
    checkOutput("flush_valid", aOutValid, 0);
    checkOutput("flush_q_held", aQ, 8'h30);
    checkOutput("flush_ready", aInReady, 1);
    for (int k = 0; k < 4; k++) begin
      tick();
      checkOutput("flush_no_word", aOutValid, 0);
    end

    $display("[TB] reset mid-stall");
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 8'(32'h40 + k), 1'b0);
      tick();
    end
    checkOutput("stall_count", aCount, 4);
    checkOutput("stall_ready", aInReady, 0);
    R = 1'b1;
    FLUSH = 1'b1;
    applyStimulus(1'b1, 8'h99, 1'b0);
    tick();
    R = 1'b0;
    FLUSH = 1'b0;
    applyStimulus(1'b0, 8'h00, 1'b1);
    #1;
    checkOutput("rr_count", aCount, 0);
    checkOutput("rr_valid", aOutValid, 0);
    checkOutput("rr_q", aQ, 8'h3C);
    checkOutput("rr_ready", aInReady, 1);
    for (int k = 0; k < 4; k++) begin
      tick();
      checkOutput("rr_no_stale", aOutValid, 0);
      checkOutput("rr_q_stays", aQ, 8'h3C);
    end

    $display("[TB] pass-through");
    bOutReady = 1'b0; bInValid = 1'b1; bD = 8'h61;
    #1;
    checkOutput("pt_ready_empty", bInReady, 1);
    tick();
    bInValid = 1'b0;
    #1;
    checkOutput("pt_ready_full", bInReady, 0);
    checkOutput("pt_valid", bOutValid, 1);
    checkOutput("pt_q", bQ, 8'h61);
    checkOutput("pt_count", bCount, 1);
    tick();
    checkOutput("pt_q_hold", bQ, 8'h61);
    checkOutput("pt_valid_hold", bOutValid, 1);
    bInValid = 1'b1; bD = 8'h62; bOutReady = 1'b1;
    #1;
    checkOutput("pt_ready_comb", bInReady, 1);
    checkOutput("pt_old_out", bQ, 8'h61);
    tick();
    checkOutput("pt_new_q", bQ, 8'h62);
    checkOutput("pt_new_valid", bOutValid, 1);
    checkOutput("pt_new_count", bCount, 1);
    bInValid = 1'b0;
    tick();
    checkOutput("pt_drained", bOutValid, 0);
    checkOutput("pt_drained_count", bCount, 0);
    checkOutput("pt_last_q", bQ, 8'h62);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
